// File: rtl/window_fetch_sched_pkg.sv
// ----------------------------------------------------------------------------
// Module : window_fetch_sched_pkg
// Shared FSM encoding, field widths and limits for the window fetch scheduler.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package window_fetch_sched_pkg;

  localparam int PIX_CH   = 16;
  localparam int MAX_FULL = 4095;
  localparam int ROW_W    = 7;
  localparam int IDX_W    = 6;
  localparam int FULL_W   = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG       = 3'd1,
    ST_CLEAR     = 3'd2,
    ST_FILL      = 3'd3,
    ST_STREAM    = 3'd4,
    ST_GROUP_END = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/window_fetch_sched_idx.sv
// ----------------------------------------------------------------------------
// Module : win_index_counter
// Output-window row/column counter chained with the depth-group counter.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module win_index_counter
  import window_fetch_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_win,
  input  logic             inc,
  input  logic             clr_grp,
  input  logic             inc_grp,
  input  logic [IDX_W-1:0] out_dim,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic [IDX_W-1:0] group,
  output logic             last
);

  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] grp_q, grp_d;
  logic [IDX_W-1:0] dim_m1;

  assign dim_m1 = out_dim - IDX_W'(1);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    grp_d = grp_q;
    if (clr_win) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (col_q == dim_m1) begin
        col_d = '0;
        row_d = (row_q == dim_m1) ? '0 : row_q + IDX_W'(1);
      end else begin
        col_d = col_q + IDX_W'(1);
      end
    end
    if (clr_grp) begin
      grp_d = '0;
    end else if (inc_grp) begin
      grp_d = grp_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      grp_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      grp_q <= grp_d;
    end
  end

  assign row   = row_q;
  assign col   = col_q;
  assign group = grp_q;
  assign last  = (row_q == dim_m1) && (col_q == dim_m1);

endmodule

`default_nettype wire

// File: rtl/window_fetch_sched.sv
// ----------------------------------------------------------------------------
// Module : window_fetch_sched
// Sequences line-buffer clear/fill/stream per depth group and hands windows on.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module window_fetch_sched
  import window_fetch_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  cfg_row_size,
  input  logic              cfg_stride,
  input  logic [IDX_W-1:0]  cfg_num_groups,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              fifo_wr_en,
  output logic              fifo_stride,
  output logic [ROW_W-1:0]  fifo_row_size,
  output logic [FULL_W-1:0] fifo_full_window_size,
  output logic              fifo_ex_window_done,
  output logic              fifo_zero_buffering,
  input  logic              fifo_data_valid,
  input  logic              fifo_depth_window_done,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [IDX_W-1:0]  win_row,
  output logic [IDX_W-1:0]  win_col,
  output logic [IDX_W-1:0]  group_idx,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int PROD_W = 2 * ROW_W;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_size_q, row_size_d;
  logic              stride_q, stride_d;
  logic [IDX_W-1:0]  num_groups_q, num_groups_d;
  logic [IDX_W-1:0]  out_dim_q, out_dim_d;
  logic [FULL_W-1:0] full_q, full_d;
  logic              cfg_err_q, cfg_err_d;

  logic [ROW_W-1:0]  cfg_dim;
  logic [PROD_W-1:0] cfg_full;
  logic              cfg_bad;
  logic              win_accept;
  logic              win_last;
  logic              win_clr, grp_clr, grp_inc;
  logic              in_stream;

  // Window ordering is driven purely by the acceptance count, so the line
  // buffer's own end-of-group flag carries no extra information here.
  logic unused_depth_done;
  assign unused_depth_done = fifo_depth_window_done;

  assign cfg_dim  = stride_q ? (row_size_q >> 1) : row_size_q;
  assign cfg_full = {{ROW_W{1'b0}}, cfg_dim} * {{ROW_W{1'b0}}, cfg_dim};
  assign cfg_bad  = (cfg_full > PROD_W'(MAX_FULL)) || (row_size_q < ROW_W'(3))
                  || (num_groups_q == '0);

  always_comb begin
    state_d      = state_q;
    row_size_d   = row_size_q;
    stride_d     = stride_q;
    num_groups_d = num_groups_q;
    out_dim_d    = out_dim_q;
    full_d       = full_q;
    cfg_err_d    = cfg_err_q;
    win_clr      = 1'b0;
    grp_clr      = 1'b0;
    grp_inc      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_size_d   = cfg_row_size;
          stride_d     = cfg_stride;
          num_groups_d = cfg_num_groups;
          win_clr      = 1'b1;
          grp_clr      = 1'b1;
          state_d      = ST_CFG;
        end
      end
      ST_CFG: begin
        if (cfg_bad) begin
          cfg_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cfg_err_d = 1'b0;
          full_d    = cfg_full[FULL_W-1:0];
          // A valid layer has out_dim <= 63, so the upper bit is always zero.
          out_dim_d = cfg_dim[IDX_W-1:0];
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR:  state_d = ST_FILL;
      ST_FILL: begin
        if (fifo_data_valid) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (win_accept && win_last) state_d = ST_GROUP_END;
      end
      ST_GROUP_END: begin
        win_clr = 1'b1;
        if (group_idx == (num_groups_q - IDX_W'(1))) begin
          state_d = ST_DONE;
        end else begin
          grp_inc = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_size_q   <= '0;
      stride_q     <= 1'b0;
      num_groups_q <= '0;
      out_dim_q    <= '0;
      full_q       <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_size_q   <= row_size_d;
      stride_q     <= stride_d;
      num_groups_q <= num_groups_d;
      out_dim_q    <= out_dim_d;
      full_q       <= full_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  win_index_counter u_idx (
    .clk     (clk),
    .rst     (rst),
    .clr_win (win_clr),
    .inc     (win_accept),
    .clr_grp (grp_clr),
    .inc_grp (grp_inc),
    .out_dim (out_dim_q),
    .row     (win_row),
    .col     (win_col),
    .group   (group_idx),
    .last    (win_last)
  );

  assign in_stream             = (state_q == ST_STREAM);
  assign pix_ready             = (state_q == ST_FILL) || in_stream;
  assign fifo_wr_en            = pix_valid & pix_ready;
  assign win_valid             = in_stream & fifo_data_valid;
  assign win_accept            = win_valid & win_ready;
  assign fifo_ex_window_done   = win_accept;
  assign fifo_zero_buffering   = (state_q == ST_CLEAR);
  assign fifo_stride           = stride_q;
  assign fifo_row_size         = row_size_q;
  assign fifo_full_window_size = full_q;
  assign busy                  = (state_q != ST_IDLE);
  assign done                  = (state_q == ST_DONE);
  assign cfg_err               = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_window_fetch_sched.sv
// ----------------------------------------------------------------------------
// Module : tb_window_fetch_sched
// Directed table-driven bench for the window fetch scheduler.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_window_fetch_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  cfg_row_size = '0;
  logic        cfg_stride = 1'b0;
  logic [5:0]  cfg_num_groups = '0;
  logic        pix_valid = 1'b1;
  logic        pix_ready;
  logic        fifo_wr_en;
  logic        fifo_stride;
  logic [6:0]  fifo_row_size;
  logic [11:0] fifo_full_window_size;
  logic        fifo_ex_window_done;
  logic        fifo_zero_buffering;
  logic        fifo_data_valid = 1'b1;
  logic        fifo_depth_window_done = 1'b0;
  logic        win_valid;
  logic        win_ready = 1'b1;
  logic [5:0]  win_row;
  logic [5:0]  win_col;
  logic [5:0]  group_idx;
  logic        busy;
  logic        done;
  logic        cfg_err;

  window_fetch_sched dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .cfg_row_size           (cfg_row_size),
    .cfg_stride             (cfg_stride),
    .cfg_num_groups         (cfg_num_groups),
    .pix_valid              (pix_valid),
    .pix_ready              (pix_ready),
    .fifo_wr_en             (fifo_wr_en),
    .fifo_stride            (fifo_stride),
    .fifo_row_size          (fifo_row_size),
    .fifo_full_window_size  (fifo_full_window_size),
    .fifo_ex_window_done    (fifo_ex_window_done),
    .fifo_zero_buffering    (fifo_zero_buffering),
    .fifo_data_valid        (fifo_data_valid),
    .fifo_depth_window_done (fifo_depth_window_done),
    .win_valid              (win_valid),
    .win_ready              (win_ready),
    .win_row                (win_row),
    .win_col                (win_col),
    .group_idx              (group_idx),
    .busy                   (busy),
    .done                   (done),
    .cfg_err                (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference monitor: counts events and tracks the expected raster order.
  int         cyc = 0, n_acc = 0, n_clr = 0, n_done = 0, n_proto = 0;
  int         last_acc_cyc = 0, done_cyc = 0;
  int         mon_dim = 1;
  logic [5:0] m_row = '0, m_col = '0, m_grp = '0;
  logic [5:0] last_row = '0, last_col = '0;

  always @(negedge clk) begin : mon
    int         v;
    logic [5:0] nr, nc, dm;
    v  = 0;
    nr = m_row;
    nc = m_col;
    dm = 6'(mon_dim - 1);
    cyc <= cyc + 1;
    if (start && !busy) m_grp <= '0;
    if (fifo_zero_buffering) begin
      if (group_idx != m_grp) v++;
      m_grp <= m_grp + 6'd1;
      n_clr <= n_clr + 1;
      nr = '0;
      nc = '0;
    end
    if (fifo_ex_window_done) begin
      if (!(win_valid && win_ready)) v++;
      if (win_row != nr || win_col != nc) v++;
      last_row     <= win_row;
      last_col     <= win_col;
      last_acc_cyc <= cyc;
      n_acc        <= n_acc + 1;
      if (nc == dm) begin
        nc = '0;
        nr = nr + 6'd1;
      end else begin
        nc = nc + 6'd1;
      end
    end
    if (win_valid && !fifo_data_valid) v++;
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
      if (pix_ready) v++;
    end
    if (!busy && (pix_ready || fifo_wr_en || win_valid || fifo_zero_buffering || done)) v++;
    if (fifo_wr_en && !pix_valid) v++;
    m_row   <= nr;
    m_col   <= nc;
    n_proto <= n_proto + v;
  end

  int b_acc, b_clr, b_done, b_proto;

  task automatic start_layer(input int rs, input int st, input int ng);
    @(posedge clk); #1;
    mon_dim        = (st != 0) ? (rs >> 1) : rs;
    b_acc          = n_acc;
    b_clr          = n_clr;
    b_done         = n_done;
    b_proto        = n_proto;
    cfg_row_size   = 7'(rs);
    cfg_stride     = (st != 0);
    cfg_num_groups = 6'(ng);
    start          = 1'b1;
    @(posedge clk); #1;
    start          = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_timeout"}, int'(k < 20000), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n);
    int k;
    k = 0;
    while ((n_acc - b_acc) < n && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_acc_timeout", int'(k < 2000), 1);
  endtask

  task automatic check_layer(input string nm, input int e_err, input int e_full,
                             input int e_win, input int ng, input int e_last,
                             input int rs, input int st);
    chk({nm, "_cfg_err"}, int'(cfg_err), e_err);
    chk({nm, "_windows"}, n_acc - b_acc, e_win);
    chk({nm, "_clears"}, n_clr - b_clr, (e_err != 0) ? 0 : ng);
    chk({nm, "_done"}, n_done - b_done, (e_err != 0) ? 0 : 1);
    chk({nm, "_proto"}, n_proto - b_proto, 0);
    chk({nm, "_busy"}, int'(busy), 0);
    if (e_err == 0) begin
      chk({nm, "_full"}, int'(fifo_full_window_size), e_full);
      chk({nm, "_row_size"}, int'(fifo_row_size), rs);
      chk({nm, "_stride"}, int'(fifo_stride), st);
      chk({nm, "_last_row"}, int'(last_row), e_last);
      chk({nm, "_last_col"}, int'(last_col), e_last);
      chk({nm, "_done_lat"}, done_cyc - last_acc_cyc, 2);
      chk({nm, "_group"}, int'(group_idx), ng - 1);
    end
  endtask

  typedef struct {
    string name;
    int    rs;
    int    st;
    int    ng;
    int    e_err;
    int    e_full;
    int    e_win;
    int    e_last;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = '{"r112s2", 112, 1, 1, 0, 3136, 3136, 55};
    vecs[1]  = '{"r8g3",     8, 0, 3, 0,   64,  192,  7};
    vecs[2]  = '{"r80big",  80, 0, 1, 1,    0,    0,  0};
    vecs[3]  = '{"r8g2",     8, 0, 2, 0,   64,  128,  7};
    vecs[4]  = '{"r2small",  2, 0, 1, 1,    0,    0,  0};
    vecs[5]  = '{"g0",      10, 0, 0, 1,    0,    0,  0};
    vecs[6]  = '{"r3s2",     3, 1, 2, 0,    1,    2,  0};
    vecs[7]  = '{"r63",     63, 0, 1, 0, 3969, 3969, 62};
    vecs[8]  = '{"r64big",  64, 0, 1, 1,    0,    0,  0};
    vecs[9]  = '{"r127s2", 127, 1, 1, 0, 3969, 3969, 62};
    vecs[10] = '{"r5g4",     5, 0, 4, 0,   25,  100,  4};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", int'({pix_ready, fifo_wr_en, fifo_stride, fifo_row_size,
                             fifo_full_window_size, fifo_ex_window_done,
                             fifo_zero_buffering, win_valid, busy, done, cfg_err} != 0), 0);
    chk("rst_indices", int'({win_row, win_col, group_idx}), 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      start_layer(vecs[i].rs, vecs[i].st, vecs[i].ng);
      wait_idle(vecs[i].name);
      check_layer(vecs[i].name, vecs[i].e_err, vecs[i].e_full, vecs[i].e_win,
                  vecs[i].ng, vecs[i].e_last, vecs[i].rs, vecs[i].st);
    end

    // Compute engine stalls for 5 cycles mid-stream
    start_layer(8, 0, 1);
    wait_acc(10);
    @(posedge clk); #1;
    win_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", int'(win_valid), 1);
      chk("stall_ex_done", int'(fifo_ex_window_done), 0);
      chk("stall_pos", int'({win_row, win_col}), int'({m_row, m_col}));
    end
    @(posedge clk); #1;
    win_ready = 1'b1;
    wait_idle("stall");
    check_layer("stall", 0, 64, 64, 1, 7, 8, 0);

    // start pulse while streaming must be ignored
    start_layer(8, 0, 1);
    wait_acc(20);
    @(posedge clk); #1;
    cfg_row_size   = 7'd20;
    cfg_stride     = 1'b1;
    cfg_num_groups = 6'd5;
    start          = 1'b1;
    @(posedge clk); #1;
    start          = 1'b0;
    wait_idle("restart");
    check_layer("restart", 0, 64, 64, 1, 7, 8, 0);

    // Asynchronous reset mid-stream, then a clean rerun
    start_layer(8, 0, 1);
    wait_acc(30);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", int'({pix_ready, fifo_wr_en, fifo_stride, fifo_row_size,
                                fifo_full_window_size, fifo_ex_window_done,
                                fifo_zero_buffering, win_valid, busy, done, cfg_err} != 0), 0);
    chk("midrst_indices", int'({win_row, win_col, group_idx}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", n_done - b_done, 0);
    chk("midrst_idle", int'(busy), 0);
    start_layer(8, 0, 2);
    wait_idle("rerun");
    check_layer("rerun", 0, 64, 128, 2, 7, 8, 0);

    // Reset also clears a sticky configuration error
    start_layer(80, 0, 1);
    wait_idle("err_rst");
    chk("err_set", int'(cfg_err), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("err_rst_cleared", int'(cfg_err), 0);
    chk("err_rst_row_size", int'(fifo_row_size), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
